pc_stack_counter: RTL and testbench

//  Parametrised program counter with an integrated hardware call/return stack.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_lifo.sv | 69 ++++++
 rtl/pc_stack_counter.sv | 122 ++++++++++++
 tb/tb_pc_stack_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / call-stack block.
//  - OP_* : decoded operation codes, listed from highest to lowest priority.
//  - sp_width(): width of the stack pointer needed to count 0..depth.
package pc_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_CLR  = 3'd0;
  localparam op_t OP_RET  = 3'd1;
  localparam op_t OP_CALL = 3'd2;
  localparam op_t OP_LOAD = 3'd3;
  localparam op_t OP_REL  = 3'd4;
  localparam op_t OP_INC  = 3'd5;
  localparam op_t OP_HOLD = 3'd6;

  // The pointer must be able to hold the value depth itself (stack full).
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_lifo.sv
// Return-address stack: DEPTH entries of ADDR_W bits with push/pop.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset (pointer only)
//  i_push      write i_data at the current pointer and advance it
//  i_pop       retreat the pointer (o_top is the value being popped)
//  i_data      return address to push
//  o_top       entry at sp-1 (valid only when not empty)
//  o_sp        occupancy 0..DEPTH
//  o_full      o_sp == DEPTH
//  o_empty     o_sp == 0
module pc_lifo
  import pc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [ADDR_W-1:0]             i_data,
  output logic [ADDR_W-1:0]             o_top,
  output logic [sp_width(DEPTH)-1:0]    o_sp,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int SP_W  = sp_width(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_do_push;
  logic              w_do_pop;

  // The pointer never exceeds DEPTH-1 when used as a write index, and
  // the read index is only meaningful when the stack is not empty.
  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_rd_idx  = IDX_W'(r_sp - SP_W'(1));

  assign o_full    = (r_sp == SP_W'(DEPTH));
  assign o_empty   = (r_sp == '0);
  assign o_sp      = r_sp;
  assign o_top     = r_mem[w_rd_idx];

  // Guard locally as well so the stack can never be corrupted.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !i_push && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Stack contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with integrated hardware call/return stack.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  ce           clock enable; when low every register holds
//  clear_pc     PC <= RESET_VEC
//  ret_pc       pop return address into PC
//  call_pc      push PC+1, PC <= adr_in
//  load_pc      PC <= adr_in
//  rel_pc       PC <= PC + signed(adr_in)
//  enable_pc    PC <= PC + 1
//  adr_in       target address or signed offset
//  adr_out      current PC (registered)
//  sp_out       stack occupancy
//  stk_empty    stack empty
//  stk_full     stack full
//  stk_ovf      sticky: call while full
//  stk_unf      sticky: return while empty
// Operations are one per cycle with priority
// clear > ret > call > load > rel > inc > hold.
module pc_stack_counter
  import pc_pkg::*;
#(
  parameter int                 ADDR_W    = 6,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        clear_pc,
  input  logic                        ret_pc,
  input  logic                        call_pc,
  input  logic                        load_pc,
  input  logic                        rel_pc,
  input  logic                        enable_pc,
  input  logic [ADDR_W-1:0]           adr_in,
  output logic [ADDR_W-1:0]           adr_out,
  output logic [sp_width(DEPTH)-1:0]  sp_out,
  output logic                        stk_empty,
  output logic                        stk_full,
  output logic                        stk_ovf,
  output logic                        stk_unf
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;

  op_t               w_op;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Priority decode of the operation strobes.
  always_comb begin
    w_op = OP_HOLD;
    if (clear_pc)       w_op = OP_CLR;
    else if (ret_pc)    w_op = OP_RET;
    else if (call_pc)   w_op = OP_CALL;
    else if (load_pc)   w_op = OP_LOAD;
    else if (rel_pc)    w_op = OP_REL;
    else if (enable_pc) w_op = OP_INC;
  end

  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Calls/returns that would over/underflow leave PC and stack untouched.
  assign w_push = ce && (w_op == OP_CALL) && !w_full;
  assign w_pop  = ce && (w_op == OP_RET)  && !w_empty;

  always_comb begin
    w_pc_nxt = r_pc;
    case (w_op)
      OP_CLR:  w_pc_nxt = RESET_VEC;
      OP_RET:  w_pc_nxt = w_empty ? r_pc : w_top;
      OP_CALL: w_pc_nxt = w_full ? r_pc : adr_in;
      OP_LOAD: w_pc_nxt = adr_in;
      // Two's-complement add of the offset; wraps silently at ADDR_W bits.
      OP_REL:  w_pc_nxt = r_pc + adr_in;
      OP_INC:  w_pc_nxt = w_pc_inc;
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_VEC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (ce) begin
      r_pc <= w_pc_nxt;
      if ((w_op == OP_CALL) && w_full)  r_ovf <= 1'b1;
      if ((w_op == OP_RET)  && w_empty) r_unf <= 1'b1;
    end
  end

  pc_lifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_sp    (sp_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign adr_out   = r_pc;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign stk_ovf   = r_ovf;
  assign stk_unf   = r_unf;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Bench for pc_stack_counter: directed scenarios followed by random
// operation streams, all compared against a queue-based reference model.
module tb_pc_stack_counter;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam int RVEC   = 0;
  localparam int MASK   = (1 << ADDR_W) - 1;

  // Operation bit patterns {clear, ret, call, load, rel, inc}.
  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_CLR  = 6'b100000;
  localparam logic [5:0] B_RET  = 6'b010000;
  localparam logic [5:0] B_CALL = 6'b001000;
  localparam logic [5:0] B_LOAD = 6'b000100;
  localparam logic [5:0] B_REL  = 6'b000010;
  localparam logic [5:0] B_INC  = 6'b000001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ce;
  logic              clear_pc, ret_pc, call_pc, load_pc, rel_pc, enable_pc;
  logic [ADDR_W-1:0] adr_in;
  logic [ADDR_W-1:0] adr_out;
  logic [SP_W-1:0]   sp_out;
  logic              stk_empty, stk_full, stk_ovf, stk_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  always #5 clk = ~clk;

  pc_stack_counter #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_VEC (ADDR_W'(RVEC))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clear_pc  (clear_pc),
    .ret_pc    (ret_pc),
    .call_pc   (call_pc),
    .load_pc   (load_pc),
    .rel_pc    (rel_pc),
    .enable_pc (enable_pc),
    .adr_in    (adr_in),
    .adr_out   (adr_out),
    .sp_out    (sp_out),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Behaviour straight from the operation rules, priority by if/else order.
  task automatic model_apply(input logic [5:0] ops, input int adr, input bit cen);
    if (!cen) return;
    if (ops[5]) begin
      m_pc = RVEC;
    end else if (ops[4]) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (ops[3]) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else begin
        m_stk.push_back((m_pc + 1) & MASK);
        m_pc = adr;
      end
    end else if (ops[2]) begin
      m_pc = adr;
    end else if (ops[1]) begin
      m_pc = (m_pc + adr) & MASK;
    end else if (ops[0]) begin
      m_pc = (m_pc + 1) & MASK;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":pc"},    32'(adr_out),   32'(m_pc));
    chk({tag, ":sp"},    32'(sp_out),    32'(m_stk.size()));
    chk({tag, ":empty"}, 32'(stk_empty), 32'(m_stk.size() == 0));
    chk({tag, ":full"},  32'(stk_full),  32'(m_stk.size() == DEPTH));
    chk({tag, ":ovf"},   32'(stk_ovf),   32'(m_ovf));
    chk({tag, ":unf"},   32'(stk_unf),   32'(m_unf));
  endtask

  task automatic step(input string tag, input logic [5:0] ops, input int adr, input bit cen);
    @(negedge clk);
    {clear_pc, ret_pc, call_pc, load_pc, rel_pc, enable_pc} = ops;
    adr_in = ADDR_W'(adr);
    ce     = cen;
    @(posedge clk);
    #1;
    model_apply(ops, adr, cen);
    check_state(tag);
  endtask

  // Asserts reset away from a clock edge and checks outputs before any edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    {clear_pc, ret_pc, call_pc, load_pc, rel_pc, enable_pc} = B_NONE;
    #1;
    model_reset();
    chk({tag, ":pc"},  32'(adr_out), 32'(RVEC));
    chk({tag, ":sp"},  32'(sp_out),  32'd0);
    chk({tag, ":ovf"}, 32'(stk_ovf), 32'd0);
    chk({tag, ":unf"}, 32'(stk_unf), 32'd0);
    check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    {clear_pc, ret_pc, call_pc, load_pc, rel_pc, enable_pc} = B_NONE;
    adr_in = '0;
    model_reset();
    #12;
    check_state("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    // Build PC=0x15, sp=2, then reset mid-run.
    step("pre_ld", B_LOAD, 'h10, 1'b1);
    step("pre_c1", B_CALL, 'h20, 1'b1);
    step("pre_c2", B_CALL, 'h30, 1'b1);
    step("pre_ld2", B_LOAD, 'h15, 1'b1);
    chk("pre_sp", 32'(sp_out), 32'd2);
    async_reset("rst_mid");

    // Increment and wrap, then clock-enable hold.
    step("ld3e", B_LOAD, 'h3E, 1'b1);
    step("inc3f", B_INC, 0, 1'b1);
    chk("inc3f_k", 32'(adr_out), 32'h3F);
    step("inc00", B_INC, 0, 1'b1);
    chk("inc00_k", 32'(adr_out), 32'h00);
    for (int i = 0; i < 3; i++) step("ce0", B_INC | B_CALL, 'h11, 1'b0);
    chk("ce0_k", 32'(adr_out), 32'h00);

    // Nested call / return.
    step("ld05", B_LOAD, 'h05, 1'b1);
    step("call20", B_CALL, 'h20, 1'b1);
    chk("call20_k", 32'(adr_out), 32'h20);
    step("call30", B_CALL, 'h30, 1'b1);
    chk("call30_sp", 32'(sp_out), 32'd2);
    step("ret21", B_RET, 0, 1'b1);
    chk("ret21_k", 32'(adr_out), 32'h21);
    step("ret06", B_RET, 0, 1'b1);
    chk("ret06_k", 32'(adr_out), 32'h06);
    chk("ret06_e", 32'(stk_empty), 32'd1);

    // Overflow on the fifth call, then underflow from empty.
    for (int i = 1; i <= 5; i++) step("ovf_call", B_CALL, i, 1'b1);
    chk("ovf_pc", 32'(adr_out), 32'h04);
    chk("ovf_sp", 32'(sp_out), 32'd4);
    chk("ovf_flag", 32'(stk_ovf), 32'd1);
    for (int i = 0; i < 4; i++) step("drain", B_RET, 0, 1'b1);
    step("unf_ret", B_RET, 0, 1'b1);
    chk("unf_flag", 32'(stk_unf), 32'd1);
    step("unf_hold1", B_LOAD, 'h2A, 1'b1);
    step("unf_hold2", B_CLR, 0, 1'b1);
    chk("unf_sticky", 32'(stk_unf), 32'd1);

    // Priority.
    step("pri_call", B_CALL, 'h12, 1'b1);
    step("pri_clr", B_CLR | B_CALL | B_INC, 'h33, 1'b1);
    chk("pri_clr_pc", 32'(adr_out), 32'(RVEC));
    chk("pri_clr_sp", 32'(sp_out), 32'd1);
    step("pri_ld", B_LOAD | B_INC, 'h27, 1'b1);
    chk("pri_ld_k", 32'(adr_out), 32'h27);
    step("pri_ret", B_RET | B_CALL, 'h3A, 1'b1);
    // Back-to-back return then call.
    step("b2b_call", B_CALL, 'h08, 1'b1);
    step("b2b_ret", B_RET, 0, 1'b1);
    step("b2b_call2", B_CALL, 'h19, 1'b1);

    // Relative branch with negative offset and wrap.
    step("ld10", B_LOAD, 'h10, 1'b1);
    step("rel0c", B_REL, 'h3C, 1'b1);
    chk("rel0c_k", 32'(adr_out), 32'h0C);
    step("ld02", B_LOAD, 'h02, 1'b1);
    step("rel3e", B_REL, 'h3C, 1'b1);
    chk("rel3e_k", 32'(adr_out), 32'h3E);

    // Sticky flags clear only by reset.
    async_reset("rst_end");

    // Random operation mix; ANDing random words keeps strobes sparse.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] r_ops;
      r_ops = 6'($urandom) & 6'($urandom);
      if ($urandom_range(0, 3) != 0) r_ops[5] = 1'b0;
      step("rand", r_ops, int'($urandom_range(0, MASK)), $urandom_range(0, 9) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
